// File: rtl/parity_serial_tx_pkg.sv
// Shared definitions for the parity serial transmitter.
// The parity slot exists only when PARITY_SERIAL_TX_PARITY_EN is defined.
package parity_serial_tx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef PARITY_SERIAL_TX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } tx_state_e;

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;

   // Serial bit slots per frame: start + payload + (parity) + stop.
   function automatic int unsigned frame_bits(input int unsigned data_w);
`ifdef PARITY_SERIAL_TX_PARITY_EN
      return data_w + 3;
`else
      return data_w + 2;
`endif
   endfunction

endpackage

// File: rtl/parity_serial_tx_bit_timer.sv
// Bit-period down-counter; bit_end strobes on the last cycle of each serial bit.
module bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic run,
   output logic bit_end
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] count;

   assign bit_end = run && (count == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load || bit_end) begin
         count <= RELOAD;
      end else if (run) begin
         count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/parity_serial_tx.sv
// Serial transmitter: start bit, LSB-first payload, optional odd-parity bit, stop bit.
// Parity slot is built only when PARITY_SERIAL_TX_PARITY_EN is defined.
module parity_serial_tx
   import parity_serial_tx_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] data_in,
   input  logic              valid,
   output logic              ready,
   output logic              tx,
   output logic              busy,
   output logic              done
);

   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

   tx_state_e         state, state_next;
   logic [DATA_W-1:0] shift_reg, shift_next, shifted;
   logic [BW-1:0]     bit_cnt, bit_cnt_next;
   logic              tx_reg, tx_next;
   logic              accept, bit_end;
`ifdef PARITY_SERIAL_TX_PARITY_EN
   logic              parity_reg, parity_next;
`endif

   assign accept  = (state == IDLE) && valid;
   assign shifted = shift_reg >> 1;

   assign tx    = tx_reg;
   assign ready = (state == IDLE);
   assign busy  = (state != IDLE);

   bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (accept),
      .run     (state != IDLE),
      .bit_end (bit_end)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         tx_reg     <= IDLE_LEVEL;
         shift_reg  <= '0;
         bit_cnt    <= '0;
`ifdef PARITY_SERIAL_TX_PARITY_EN
         parity_reg <= 1'b0;
`endif
      end else begin
         state      <= state_next;
         tx_reg     <= tx_next;
         shift_reg  <= shift_next;
         bit_cnt    <= bit_cnt_next;
`ifdef PARITY_SERIAL_TX_PARITY_EN
         parity_reg <= parity_next;
`endif
      end
   end

   // tx_next is the level of the bit that starts at the coming edge, so tx stays registered.
   always_comb begin
      state_next   = state;
      tx_next      = tx_reg;
      shift_next   = shift_reg;
      bit_cnt_next = bit_cnt;
      done         = 1'b0;
`ifdef PARITY_SERIAL_TX_PARITY_EN
      parity_next  = parity_reg;
`endif
      case (state)
         IDLE: begin
            if (valid) begin
               state_next   = START;
               tx_next      = START_LEVEL;
               shift_next   = data_in;
               bit_cnt_next = '0;
`ifdef PARITY_SERIAL_TX_PARITY_EN
               parity_next  = ~^data_in;
`endif
            end
         end
         START: begin
            if (bit_end) begin
               state_next = DATA;
               tx_next    = shift_reg[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_cnt == LAST_BIT) begin
`ifdef PARITY_SERIAL_TX_PARITY_EN
                  state_next = PARITY;
                  tx_next    = parity_reg;
`else
                  state_next = STOP;
                  tx_next    = IDLE_LEVEL;
`endif
               end else begin
                  bit_cnt_next = bit_cnt + BW'(1);
                  shift_next   = shifted;
                  tx_next      = shifted[0];
               end
            end
         end
`ifdef PARITY_SERIAL_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               state_next = STOP;
               tx_next    = IDLE_LEVEL;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               state_next = IDLE;
               done       = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            tx_next    = IDLE_LEVEL;
         end
      endcase
   end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Scoreboard bench for parity_serial_tx (DATA_W=8, CLKS_PER_BIT=4).
// Expected frames follow PARITY_SERIAL_TX_PARITY_EN the same way the design build does.
module tb_parity_serial_tx;

   localparam int CLKS = 4;
`ifdef PARITY_SERIAL_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
   localparam int FRAME_LEN  = 44;
`else
   localparam int FRAME_BITS = 10;
   localparam int FRAME_LEN  = 40;
`endif

   typedef struct {
      logic [15:0] bits;
      int          len;
   } frame_t;

   logic       clk;
   logic       rst_n;
   logic [7:0] data_in;
   logic       valid;
   logic       ready;
   logic       tx;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   frame_t expect_q[$];
   int     gap_q[$];

   parity_serial_tx #(
      .DATA_W       (8),
      .CLKS_PER_BIT (CLKS)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .data_in (data_in),
      .valid   (valid),
      .ready   (ready),
      .tx      (tx),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic failNow(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: got event, expected none", name);
   endtask

   // Waits for an IDLE cycle, requests the byte and queues its hand-derived frame.
   task automatic applyStimulus(input logic [7:0] d, input logic par, input bit hold);
      frame_t f;
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ready && n < 200);
      if (!ready) failNow("ready_timeout");
      data_in = d;
      valid   = 1'b1;
      f.bits    = '0;
      f.bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) f.bits[1 + i] = d[i];
      f.bits[9] = par;
      f.bits[FRAME_BITS - 1] = 1'b1;
      f.len = FRAME_LEN;
      expect_q.push_back(f);
      @(negedge clk);
      if (!hold) valid = 1'b0;
      data_in = ~d;
   endtask

   task automatic waitIdle(input int maxc);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy || expect_q.size() != 0) && n < maxc);
      if (n >= maxc) failNow("idle_timeout");
      repeat (3) @(negedge clk);
   endtask

   // Monitor: compares every in-frame cycle of tx and the frame length at done.
   bit     in_frame = 0;
   bit     have_exp = 0;
   bit     post_done = 0;
   int     frame_cycles = 0;
   int     tx_errs = 0;
   int     idle_cnt = 0;
   frame_t cur;

   always @(negedge clk) begin
      if (!rst_n) begin
         in_frame     = 0;
         have_exp     = 0;
         post_done    = 0;
         frame_cycles = 0;
         idle_cnt     = 0;
      end else begin
         if (post_done) begin
            post_done = 0;
            checkOutput("done_then_ready", {30'd0, done, ready}, 1);
         end
         if (busy) begin
            if (!in_frame) begin
               in_frame     = 1;
               frame_cycles = 0;
               tx_errs      = 0;
               gap_q.push_back(idle_cnt);
               idle_cnt = 0;
               if (expect_q.size() == 0) begin
                  have_exp = 0;
                  failNow("unexpected_frame");
               end else begin
                  cur      = expect_q[0];
                  have_exp = 1;
               end
            end
            if (have_exp) begin
               if (frame_cycles / CLKS >= FRAME_BITS) tx_errs++;
               else if (tx !== cur.bits[frame_cycles / CLKS]) tx_errs++;
            end
            frame_cycles++;
            if (done) begin
               done_cnt++;
               if (have_exp) begin
                  checkOutput("frame_tx", tx_errs, 0);
                  checkOutput("frame_len", frame_cycles, cur.len);
                  void'(expect_q.pop_front());
               end
               in_frame  = 0;
               have_exp  = 0;
               post_done = 1;
            end
         end else begin
            if (done) failNow("done_while_idle");
            if (in_frame) begin
               failNow("frame_without_done");
               if (have_exp) void'(expect_q.pop_front());
               in_frame = 0;
               have_exp = 0;
            end
            idle_cnt++;
         end
      end
   end

   initial begin
      int d0;
      rst_n   = 1'b0;
      valid   = 1'b0;
      data_in = 8'h00;
      #12;
      checkOutput("reset_tx", int'(tx), 1);
      checkOutput("reset_ready", int'(ready), 1);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_done", int'(done), 0);
      @(negedge clk);
      #1 rst_n = 1'b1;

      $display("[TB] frames A5, 07, FF");
      applyStimulus(8'hA5, 1'b1, 0);
      waitIdle(200);
      applyStimulus(8'h07, 1'b0, 0);
      waitIdle(200);
      applyStimulus(8'hFF, 1'b1, 0);
      waitIdle(200);

      $display("[TB] valid pulse while busy");
      d0 = done_cnt;
      applyStimulus(8'hA5, 1'b1, 0);
      repeat (9) @(negedge clk);
      data_in = 8'h3C;
      valid   = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      waitIdle(200);
      repeat (20) @(negedge clk);
      checkOutput("ignored_valid_dones", done_cnt - d0, 1);

      $display("[TB] back-to-back frames");
      d0 = done_cnt;
      gap_q.delete();
      applyStimulus(8'h3C, 1'b1, 1);
      applyStimulus(8'h81, 1'b1, 1);
      applyStimulus(8'h01, 1'b0, 0);
      waitIdle(400);
      checkOutput("b2b_dones", done_cnt - d0, 3);
      checkOutput("b2b_frames_seen", gap_q.size(), 3);
      if (gap_q.size() >= 3) begin
         checkOutput("b2b_gap1", gap_q[1], 1);
         checkOutput("b2b_gap2", gap_q[2], 1);
      end

      $display("[TB] reset during data bit 3");
      d0 = done_cnt;
      applyStimulus(8'h5A, 1'b1, 0);
      repeat (17) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("abort_tx", int'(tx), 1);
      checkOutput("abort_ready", int'(ready), 1);
      checkOutput("abort_busy", int'(busy), 0);
      checkOutput("abort_done", int'(done), 0);
      expect_q.delete();
      repeat (5) @(negedge clk);
      checkOutput("abort_no_done", done_cnt - d0, 0);
      begin
         frame_t f;
         data_in = 8'h07;
         valid   = 1'b1;
         f.bits    = '0;
         for (int i = 0; i < 8; i++) f.bits[1 + i] = data_in[i];
         f.bits[9] = 1'b0;
         f.bits[FRAME_BITS - 1] = 1'b1;
         f.len = FRAME_LEN;
         expect_q.push_back(f);
      end
      #1 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("first_edge_accept", int'(busy), 1);
      valid   = 1'b0;
      data_in = 8'hF8;
      waitIdle(200);

      checkOutput("queue_empty", expect_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
